// File: rtl/alu_result_signature.sv
// -----------------------------------------------------------------------------
// alu_result_signature
//
// Purpose:
//   Downstream stage of the ALU frequency-measurement wrapper. After a start
//   pulse it ignores the first SKIP clock edges so the upstream pipeline can
//   flush. It then compresses SAMPLES consecutive ALU results {cout, Q} into
//   an (N+1)-bit rotate-XOR signature. It also counts the samples taken and
//   the samples that had carry set. A whole stress run can then be checked
//   on the board by reading a single register.
//
// Parameters:
//   N        ALU data width; the signature is N+1 bits wide
//   SAMPLES  number of results compressed per run (>= 1)
//   SKIP     edges ignored after start to flush upstream (>= 0)
//   CW       width of the count outputs; 2**CW must exceed SAMPLES
//
// Ports:
//   CLK           in   1    single clock, rising edge active
//   RST           in   1    asynchronous active-high reset
//   start         in   1    start pulse, honoured only in IDLE or DONE
//   Q             in   N    ALU result (upstream updates it on negedge CLK)
//   cout          in   1    ALU carry out (upstream updates it on negedge CLK)
//   busy          out  1    high while flushing or capturing
//   done          out  1    high once a run has finished; results are stable
//   signature     out  N+1  rotate-XOR signature of {cout, Q}
//   sample_count  out  CW   samples compressed so far
//   carry_count   out  CW   compressed samples that had cout == 1
// -----------------------------------------------------------------------------
module alu_result_signature #(
  parameter int N       = 128,
  parameter int SAMPLES = 256,
  parameter int SKIP    = 2,
  parameter int CW      = 9
) (
  input  logic          CLK,
  input  logic          RST,
  input  logic          start,
  input  logic [N-1:0]  Q,
  input  logic          cout,
  output logic          busy,
  output logic          done,
  output logic [N:0]    signature,
  output logic [CW-1:0] sample_count,
  output logic [CW-1:0] carry_count
);

  // State encoding
  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_FLUSH = 2'd1;
  localparam logic [1:0] S_RUN   = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  // The skip counter must hold at least one bit, even when SKIP is 0.
  localparam int SW = (SKIP > 0) ? $clog2(SKIP + 1) : 1;

  // Terminal values: the last flush edge and the last capture edge.
  localparam logic [SW-1:0] SKIP_LAST    = SW'((SKIP > 0) ? (SKIP - 1) : 0);
  localparam logic [CW-1:0] SAMPLES_LAST = CW'(SAMPLES - 1);

  // Choose the state after an accepted start. With SKIP == 0 there is
  // nothing to flush, so capture begins on the very next edge.
  localparam logic [1:0] S_AFTER_START = (SKIP > 0) ? S_FLUSH : S_RUN;

  logic [1:0]    state_q,  state_d;
  logic [SW-1:0] skip_q,   skip_d;
  logic [N:0]    sig_q,    sig_d;
  logic [CW-1:0] scnt_q,   scnt_d;
  logic [CW-1:0] ccnt_q,   ccnt_d;

  // Next-state and datapath logic for the run sequencer
  always_comb begin
    state_d = state_q;
    skip_d  = skip_q;
    sig_d   = sig_q;
    scnt_d  = scnt_q;
    ccnt_d  = ccnt_q;

    case (state_q)
      S_IDLE, S_DONE: begin
        // A new run starts from a clean slate, so the previous results
        // are lost once start is accepted.
        if (start) begin
          state_d = S_AFTER_START;
          skip_d  = '0;
          sig_d   = '0;
          scnt_d  = '0;
          ccnt_d  = '0;
        end else begin
          state_d = state_q;
        end
      end

      S_FLUSH: begin
        // Q and cout are ignored here; only the flush edges are counted.
        if (skip_q == SKIP_LAST) begin
          state_d = S_RUN;
        end else begin
          skip_d = skip_q + {{(SW-1){1'b0}}, 1'b1};
        end
      end

      S_RUN: begin
        // Rotate left by one (the MSB wraps into bit 0), then fold in the
        // new sample.
        sig_d  = {sig_q[N-1:0], sig_q[N]} ^ {cout, Q};
        scnt_d = scnt_q + {{(CW-1){1'b0}}, 1'b1};
        ccnt_d = ccnt_q + {{(CW-1){1'b0}}, cout};
        if (scnt_q == SAMPLES_LAST) begin
          state_d = S_DONE;
        end else begin
          state_d = S_RUN;
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State and result registers; RST clears them at once, even mid-run
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q <= S_IDLE;
      skip_q  <= '0;
      sig_q   <= '0;
      scnt_q  <= '0;
      ccnt_q  <= '0;
    end else begin
      state_q <= state_d;
      skip_q  <= skip_d;
      sig_q   <= sig_d;
      scnt_q  <= scnt_d;
      ccnt_q  <= ccnt_d;
    end
  end

  // Status flags are decoded straight from the registered state
  assign busy         = (state_q == S_FLUSH) || (state_q == S_RUN);
  assign done         = (state_q == S_DONE);
  assign signature    = sig_q;
  assign sample_count = scnt_q;
  assign carry_count  = ccnt_q;

endmodule

// File: tb/tb_alu_result_signature.sv
// -----------------------------------------------------------------------------
// tb_alu_result_signature
//   Directed bench for alu_result_signature with N=8, SAMPLES=4, SKIP=2, CW=3.
//   The bench drives Q/cout/start on negedge, as the upstream wrapper does.
//   An edge-counting reference model runs alongside the directed vectors and
//   is compared with the DUT after every rising edge. The directed vectors
//   also check hand-computed literal signatures.
// -----------------------------------------------------------------------------
module tb_alu_result_signature;

  localparam int N       = 8;
  localparam int SAMPLES = 4;
  localparam int SKIP    = 2;
  localparam int CW      = 3;

  logic          CLK = 1'b0;
  logic          RST;
  logic          start;
  logic [N-1:0]  Q;
  logic          cout;
  logic          busy;
  logic          done;
  logic [N:0]    signature;
  logic [CW-1:0] sample_count;
  logic [CW-1:0] carry_count;

  int errors = 0;
  int checks = 0;

  alu_result_signature #(
    .N(N), .SAMPLES(SAMPLES), .SKIP(SKIP), .CW(CW)
  ) dut (
    .CLK          (CLK),
    .RST          (RST),
    .start        (start),
    .Q            (Q),
    .cout         (cout),
    .busy         (busy),
    .done         (done),
    .signature    (signature),
    .sample_count (sample_count),
    .carry_count  (carry_count)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // The model counts edges since the accepted start. Edges 1..SKIP are
  // flush edges. Edges SKIP+1..SKIP+SAMPLES each fold one sample into the
  // signature.
  bit         m_active = 1'b0;
  bit         m_done   = 1'b0;
  int         m_edge   = 0;
  logic [N:0] m_sig    = '0;
  int         m_sc     = 0;
  int         m_cc     = 0;

  always @(posedge RST) begin
    m_active = 1'b0;
    m_done   = 1'b0;
    m_edge   = 0;
    m_sig    = '0;
    m_sc     = 0;
    m_cc     = 0;
  end

  always @(posedge CLK) begin
    if (!RST) begin
      if (!m_active) begin
        if (start) begin
          m_active = 1'b1;
          m_done   = 1'b0;
          m_edge   = 0;
          m_sig    = '0;
          m_sc     = 0;
          m_cc     = 0;
        end
      end else begin
        m_edge++;
        if (m_edge > SKIP) begin
          m_sig = ((m_sig << 1) | (m_sig >> N)) ^ {cout, Q};
          m_sc  = m_sc + 1;
          m_cc  = m_cc + (cout ? 1 : 0);
          if (m_sc == SAMPLES) begin
            m_active = 1'b0;
            m_done   = 1'b1;
          end
        end
      end
      #1;
      if (!RST) begin
        chk("model_busy",   32'(busy),         32'(m_active));
        chk("model_done",   32'(done),         32'(m_done));
        chk("model_sig",    32'(signature),    32'(m_sig));
        chk("model_scount", 32'(sample_count), 32'(m_sc));
        chk("model_ccount", 32'(carry_count),  32'(m_cc));
      end
    end
  end

  // ---------------- directed helpers ----------------
  task automatic check_reset_outputs(input string tag);
    chk({tag, "_busy"},   32'(busy),         32'd0);
    chk({tag, "_done"},   32'(done),         32'd0);
    chk({tag, "_sig"},    32'(signature),    32'd0);
    chk({tag, "_scount"}, 32'(sample_count), 32'd0);
    chk({tag, "_ccount"}, 32'(carry_count),  32'd0);
  endtask

  // Runs one full capture with Q/cout held. exp_seq packs the four expected
  // signatures with the first capture in the most significant slot.
  task automatic run_seq(input string tag, input logic [N-1:0] q, input logic c,
                         input logic [4*(N+1)-1:0] exp_seq, input int exp_cc);
    @(negedge CLK);
    Q     = q;
    cout  = c;
    start = 1'b1;
    @(negedge CLK);             // edge 0 has accepted start
    start = 1'b0;
    for (int e = 1; e <= SKIP; e++) begin
      @(posedge CLK); #1;
      chk({tag, "_flush_busy"}, 32'(busy), 32'd1);
      chk({tag, "_flush_done"}, 32'(done), 32'd0);
    end
    for (int i = 0; i < SAMPLES; i++) begin
      @(posedge CLK); #1;
      chk({tag, "_sig_step"}, 32'(signature), 32'(exp_seq[(SAMPLES-1-i)*(N+1) +: (N+1)]));
      chk({tag, "_scount_step"}, 32'(sample_count), 32'(i + 1));
      if (i < SAMPLES - 1) chk({tag, "_done_early"}, 32'(done), 32'd0);
    end
    chk({tag, "_done"},   32'(done),         32'd1);
    chk({tag, "_busy"},   32'(busy),         32'd0);
    chk({tag, "_ccount"}, 32'(carry_count),  32'(exp_cc));
  endtask

  task automatic wait_done(input string tag, input int budget);
    bit seen = 1'b0;
    for (int k = 0; k < budget && !seen; k++) begin
      @(negedge CLK);
      if (done) seen = 1'b1;
    end
    chk({tag, "_done_within_budget"}, 32'(seen), 32'd1);
  endtask

  // ---------------- directed stimulus ----------------
  initial begin
    RST   = 1'b1;
    start = 1'b0;
    Q     = '0;
    cout  = 1'b0;
    #1;
    check_reset_outputs("por");
    repeat (2) @(negedge CLK);
    RST = 1'b0;

    // All-zero data: the signature stays at zero.
    run_seq("zero", 8'h00, 1'b0, {9'h000, 9'h000, 9'h000, 9'h000}, 0);
    chk("zero_scount", 32'(sample_count), 32'd4);

    // Constant 0x01: the rotate shifts in ones, giving 1, 3, 7, F.
    run_seq("q01", 8'h01, 1'b0, {9'h001, 9'h003, 9'h007, 9'h00F}, 0);

    // DONE holds its results while the inputs keep changing.
    @(negedge CLK);
    Q    = 8'hFF;
    cout = 1'b1;
    repeat (3) @(negedge CLK);
    chk("frozen_sig",    32'(signature),    32'h00F);
    chk("frozen_done",   32'(done),         32'd1);
    chk("frozen_ccount", 32'(carry_count),  32'd0);

    // Restart from DONE with {1,0x01} = 0x101:
    // 0x101 -> 0x003^0x101=0x102 -> 0x005^0x101=0x104 -> 0x009^0x101=0x108.
    run_seq("restart", 8'h01, 1'b1, {9'h101, 9'h102, 9'h104, 9'h108}, 4);
    chk("restart_scount", 32'(sample_count), 32'd4);

    // Carry only: 0x100, 0x101, 0x103, 0x107.
    run_seq("carry", 8'h00, 1'b1, {9'h100, 9'h101, 9'h103, 9'h107}, 4);

    // start pulsed mid-RUN is ignored. With {1,0xA5} = 0x1A5 held:
    // 0x1A5 -> 0x0EE -> 0x079 -> 0x157.
    @(negedge CLK);
    Q     = 8'hA5;
    cout  = 1'b1;
    start = 1'b1;
    @(negedge CLK);
    start = 1'b0;
    repeat (3) @(negedge CLK);  // edges 1..3 done, so the FSM is in RUN
    start = 1'b1;
    @(negedge CLK);
    start = 1'b0;
    wait_done("midstart", 20);
    chk("midstart_sig",    32'(signature),    32'h157);
    chk("midstart_scount", 32'(sample_count), 32'd4);
    chk("midstart_ccount", 32'(carry_count),  32'd4);

    // RST between edges in the middle of a run.
    @(negedge CLK);
    Q     = 8'h3C;
    cout  = 1'b1;
    start = 1'b1;
    @(negedge CLK);
    start = 1'b0;
    repeat (3) @(negedge CLK);
    #2;
    RST = 1'b1;
    #1;
    check_reset_outputs("midrst");
    @(negedge CLK);
    RST = 1'b0;
    @(posedge CLK); #1;
    chk("midrst_idle_busy", 32'(busy), 32'd0);

    // The next run after the reset must behave normally.
    run_seq("after_rst", 8'h01, 1'b0, {9'h001, 9'h003, 9'h007, 9'h00F}, 0);

    // Async reset from DONE, between edges, while the outputs are non-zero.
    @(negedge CLK);
    #2;
    RST = 1'b1;
    #1;
    check_reset_outputs("donerst");
    @(negedge CLK);
    RST = 1'b0;
    repeat (2) @(negedge CLK);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
